// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ready handshake,
// buffers a fetched word across ID stalls and squashes on downstream redirects.
`timescale 1ns/1ps

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        fetch_en,
  output logic [31:0] IR,
  output logic [31:0] PC
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] pc_tgt, pc_tgt_nxt;
  logic [XLEN-1:0] ir_buf, ir_buf_nxt;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redir_pc;
  logic            unused_redir_lsb;

  assign pc_plus4         = pc + XLEN'(4);
  assign redir_pc         = {redirect_pc[31:2], 2'b00};
  assign unused_redir_lsb = ^redirect_pc[1:0];

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= {RESET_PC[31:2], 2'b00};
      pc_tgt <= '0;
      ir_buf <= '0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      pc_tgt <= pc_tgt_nxt;
      ir_buf <= ir_buf_nxt;
    end
  end

  // Next-state and register updates; redirect always outranks stall
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    pc_tgt_nxt = pc_tgt;
    ir_buf_nxt = ir_buf;
    case (state)
      IDLE: begin
        state_nxt = REQ;
        if (redirect) pc_nxt = redir_pc;
      end
      REQ: begin
        if (redirect && imem_ready) begin
          pc_nxt = redir_pc;
        end else if (redirect) begin
          pc_tgt_nxt = redir_pc;
          state_nxt  = DRAIN;
        end else if (imem_ready && !stall) begin
          pc_nxt = pc_plus4;
        end else if (imem_ready) begin
          ir_buf_nxt = imem_rdata;
          state_nxt  = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_nxt    = redir_pc;
          state_nxt = REQ;
        end else if (!stall) begin
          pc_nxt    = pc_plus4;
          state_nxt = REQ;
        end
      end
      DRAIN: begin
        // Outstanding request must complete at the old address before retargeting
        if (imem_ready) begin
          pc_nxt    = redirect ? redir_pc : pc_tgt;
          state_nxt = REQ;
        end else if (redirect) begin
          pc_tgt_nxt = redir_pc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory request and IF/ID drive; a redirect writes a zero bubble
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = '0;
    fetch_en  = 1'b0;
    IR        = '0;
    PC        = '0;
    case (state)
      REQ: begin
        imem_req  = 1'b1;
        imem_addr = pc;
        if (redirect) begin
          fetch_en = 1'b1;
        end else if (imem_ready && !stall) begin
          fetch_en = 1'b1;
          IR       = imem_rdata;
          PC       = pc_plus4;
        end
      end
      HOLD: begin
        IR = ir_buf;
        PC = pc_plus4;
        if (redirect) begin
          fetch_en = 1'b1;
          IR       = '0;
          PC       = '0;
        end else if (!stall) begin
          fetch_en = 1'b1;
        end
      end
      DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = pc;
        fetch_en  = redirect;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a credit-driven memory model answers requests,
// a negedge monitor checks every completed address and every IF/ID write.
`timescale 1ns/1ps

module tb_if_fetch_unit;

  localparam logic [31:0] PAT = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        fetch_en;
  logic [31:0] IR;
  logic [31:0] PC;

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .fetch_en(fetch_en),
    .IR(IR), .PC(PC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: answers only while credits remain, after wait_n pending cycles
  int unsigned given, used, cnt, wait_n;
  assign imem_ready = imem_req && (given > used) && (cnt >= wait_n);
  assign imem_rdata = imem_addr ^ PAT;

  always @(posedge clk) begin
    if (reset) cnt <= 0;
    else if (imem_ready) begin
      cnt  <= 0;
      used <= used + 1;
    end else if (imem_req && given > used) cnt <= cnt + 1;
  end

  int n_cmp, n_err;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_ir[$];
  logic [31:0] exp_pc[$];
  logic        last_pend;
  logic [31:0] last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_fetch(input logic [31:0] a, input logic [31:0] ir, input logic [31:0] pc);
    exp_addr.push_back(a);
    exp_ir.push_back(ir);
    exp_pc.push_back(pc);
  endtask

  task automatic push_bubble();
    exp_ir.push_back(32'h0);
    exp_pc.push_back(32'h0);
  endtask

  // Monitor: pops expectations whenever the DUT completes a request or writes IF/ID
  always @(negedge clk) begin
    logic [31:0] e_a, e_i, e_p;
    if (reset) begin
      last_pend = 1'b0;
    end else begin
      if (imem_req && imem_ready) begin
        if (exp_addr.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL addr_unexpected: got %08h expected none at %0t", imem_addr, $time);
        end else begin
          e_a = exp_addr.pop_front();
          chk("imem_addr", imem_addr, e_a);
        end
      end
      if (imem_req && !imem_ready && last_pend) chk("addr_stable", imem_addr, last_addr);
      last_pend = imem_req && !imem_ready;
      last_addr = imem_addr;
      if (fetch_en) begin
        if (exp_ir.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL fetch_unexpected: got IR=%08h PC=%08h expected none at %0t", IR, PC, $time);
        end else begin
          e_i = exp_ir.pop_front();
          e_p = exp_pc.pop_front();
          chk("IR", IR, e_i);
          chk("PC", PC, e_p);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name);
    int k;
    k = 0;
    while ((exp_addr.size() != 0 || exp_ir.size() != 0 || given != used) && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: got %0d addr/%0d fetch pending expected 0", name,
               exp_addr.size(), exp_ir.size());
    end
    tick();
    tick();
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_req"}, 32'(imem_req), 32'h0);
    chk({name, "_addr"}, imem_addr, 32'h0);
    chk({name, "_en"}, 32'(fetch_en), 32'h0);
    chk({name, "_ir"}, IR, 32'h0);
    chk({name, "_pc"}, PC, 32'h0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    given = 0; used = 0; wait_n = 0; last_pend = 1'b0; last_addr = '0;

    // Zero-wait stream from RESET_PC=FFFF_FFFC, wrapping to 0
    repeat (3) tick();
    chk_outputs_zero("reset");
    push_fetch(32'hFFFF_FFFC, 32'hFFFF_FFFC ^ PAT, 32'h0000_0000);
    for (int i = 0; i < 4; i++)
      push_fetch(32'(i * 4), 32'(i * 4) ^ PAT, 32'(i * 4 + 4));
    given = 5;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_req", 32'(imem_req), 32'h0);
    chk("idle_en", 32'(fetch_en), 32'h0);
    @(negedge clk);
    chk("first_en", 32'(fetch_en), 32'h1);
    wait_empty("stream");

    // Two wait states per request
    wait_n = 2;
    for (int i = 0; i < 3; i++)
      push_fetch(32'h10 + 32'(i * 4), (32'h10 + 32'(i * 4)) ^ PAT, 32'h14 + 32'(i * 4));
    given += 3;
    wait_empty("waits");

    // Stall as instruction@0x1C returns, released after three cycles
    wait_n = 0;
    stall = 1'b1;
    push_fetch(32'h1C, 32'h1C ^ PAT, 32'h20);
    given += 1;
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hold_req", 32'(imem_req), 32'h0);
      chk("hold_en", 32'(fetch_en), 32'h0);
      tick();
    end
    stall = 1'b0;
    push_fetch(32'h20, 32'h20 ^ PAT, 32'h24);
    given += 1;
    @(negedge clk);
    chk("release_req", 32'(imem_req), 32'h0);
    wait_empty("stall");

    // Redirect during a wait: bubble, drain 0x24, then fetch masked target 0x100
    wait_n = 2;
    redirect = 1'b1; redirect_pc = 32'h103;
    push_bubble();
    exp_addr.push_back(32'h24);
    given += 1;
    tick();
    redirect = 1'b0;
    wait_empty("drain");
    push_fetch(32'h100, 32'h100 ^ PAT, 32'h104);
    given += 1;
    wait_empty("target");

    // Redirect beats stall in HOLD, then two redirects in DRAIN: latest wins
    wait_n = 0;
    stall = 1'b1;
    exp_addr.push_back(32'h104);
    given += 1;
    tick();
    redirect = 1'b1; redirect_pc = 32'h200;
    push_bubble();
    tick();
    wait_n = 3;
    redirect_pc = 32'h300;
    push_bubble();
    given += 1;
    tick();
    redirect_pc = 32'h400;
    push_bubble();
    tick();
    redirect = 1'b0; stall = 1'b0;
    exp_addr.push_back(32'h200);
    wait_empty("redir2");
    wait_n = 0;
    push_fetch(32'h400, 32'h400 ^ PAT, 32'h404);
    given += 1;
    wait_empty("latest");

    // Redirect coinciding with ready in REQ: data discarded, target taken at once
    redirect = 1'b1; redirect_pc = 32'h802;
    push_bubble();
    exp_addr.push_back(32'h404);
    given += 1;
    tick();
    redirect = 1'b0;
    push_fetch(32'h800, 32'h800 ^ PAT, 32'h804);
    push_fetch(32'h804, 32'h804 ^ PAT, 32'h808);
    given += 2;
    wait_empty("redir_ready");

    // Reset mid-DRAIN drops everything asynchronously, restart at RESET_PC
    wait_n = 3;
    redirect = 1'b1; redirect_pc = 32'h500;
    push_bubble();
    given += 1;
    tick();
    redirect = 1'b0;
    reset = 1'b1;
    #1;
    chk_outputs_zero("async_reset");
    given = used;
    tick();
    tick();
    wait_n = 0;
    push_fetch(32'hFFFF_FFFC, 32'hFFFF_FFFC ^ PAT, 32'h0000_0000);
    given += 1;
    reset = 1'b0;
    wait_empty("restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
